decompose_pipe_hs: RTL and testbench

- Parametrised successor to the team's fixed two-stage composed-function pipeline: computes f(x) = m(n(x)), where n = fractional square root and m = parabolic sine approximation.
- Adds valid/ready handshaking with backpressure, a per-sample mode select, and a width-generic, fully pipelined bit-serial square root.
- Sits in the DSP datapath between sample sources and downstream consumers; accepts one sample per cycle when not stalled.

---
 rtl/decompose_pipe_hs.sv | 205 ++++++++++++++++++++
 tb/tb_decompose_pipe_hs.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/decompose_pipe_hs.sv
// decompose_pipe_hs: handshaked pipeline computing f(x) = m(n(x)), where
// n is a bit-serial restoring fractional square root (one root bit per stage)
// and m is the parabolic sine approximation 4*t*(1-t).
// Per-sample mode: 0 = compose, 1 = sqrt only, 2 = sine only, 3 = bypass.
// Every mode goes through the same pipeline. The latency is WIDTH/2 + 2
// advancing cycles, so results come out in the order the samples went in.
// Optional build macro DECOMPOSE_DBG_CNT_EN adds accept and stall counters.
module decompose_pipe_hs #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef DECOMPOSE_DBG_CNT_EN
    ,
    output logic [15:0]      dbg_acc_cnt,
    output logic [15:0]      dbg_stall_cnt
`endif
);

    localparam int SQRT_STAGES = WIDTH / 2;
    localparam int HALF        = WIDTH / 2;
    localparam int RW          = HALF + 2;       // remainder width
    localparam int PW          = 2 * WIDTH + 1;  // sine product width

    typedef enum logic [1:0] {
        MODE_COMPOSE = 2'd0,
        MODE_SQRT    = 2'd1,
        MODE_SINE    = 2'd2,
        MODE_BYPASS  = 2'd3
    } mode_e;

    // One restoring step: bring down two radicand bits and try the next root bit.
    function automatic logic [RW+HALF-1:0] sqrt_step(
        input logic [RW-1:0]   rem,
        input logic [HALF-1:0] root,
        input logic [1:0]      pair
    );
        logic [RW-1:0] acc;
        logic [RW-1:0] trial;
        acc   = (rem << 2) | RW'(pair);
        trial = {root, 2'b01};
        if (acc >= trial)
            return {acc - trial, root[HALF-2:0], 1'b1};
        else
            return {acc, root[HALF-2:0], 1'b0};
    endfunction

    logic adv;

    // Square-root stage registers
    logic [SQRT_STAGES-1:0] sq_vld;
    logic [RW-1:0]          sq_rem  [SQRT_STAGES];
    logic [HALF-1:0]        sq_root [SQRT_STAGES];
    logic [WIDTH-1:0]       sq_x    [SQRT_STAGES];
    mode_e                  sq_mode [SQRT_STAGES];

    // Stage inputs (stage 0 fed from the port) and computed next values
    logic [RW-1:0]          src_rem  [SQRT_STAGES];
    logic [HALF-1:0]        src_root [SQRT_STAGES];
    logic [WIDTH-1:0]       src_x    [SQRT_STAGES];
    mode_e                  src_mode [SQRT_STAGES];
    logic [RW-1:0]          nxt_rem  [SQRT_STAGES];
    logic [HALF-1:0]        nxt_root [SQRT_STAGES];
    logic [RW+HALF-1:0]     step_res;

    // Sine stage registers
    logic                   sn_vld;
    logic [WIDTH-1:0]       sn_s;
    logic [WIDTH-1:0]       sn_y;
    logic [WIDTH-1:0]       sn_x;
    mode_e                  sn_mode;

    // Sine stage combinational values
    logic [WIDTH-1:0]       y_val;
    logic [WIDTH-1:0]       t_val;
    logic [WIDTH-1:0]       s_val;
    logic [PW-1:0]          t_ext;
    logic [PW-1:0]          comp;
    logic [PW-1:0]          prod;
    logic [PW-1:0]          s_ext;
    logic [WIDTH-1:0]       out_sel;

    // Global advance: the whole pipe moves only when the output can move
    always_comb begin
        adv      = !out_valid || out_ready;
        in_ready = adv;
    end

    // Route stage inputs and evaluate one root bit per stage
    always_comb begin
        src_rem[0]  = '0;
        src_root[0] = '0;
        src_x[0]    = in_data;
        src_mode[0] = mode_e'(in_mode);
        for (int unsigned k = 1; k < SQRT_STAGES; k++) begin
            src_rem[k]  = sq_rem[k-1];
            src_root[k] = sq_root[k-1];
            src_x[k]    = sq_x[k-1];
            src_mode[k] = sq_mode[k-1];
        end
        step_res = '0;
        for (int unsigned k = 0; k < SQRT_STAGES; k++) begin
            step_res    = sqrt_step(src_rem[k], src_root[k],
                                    src_x[k][WIDTH-1-2*k -: 2]);
            nxt_rem[k]  = step_res[RW+HALF-1:HALF];
            nxt_root[k] = step_res[HALF-1:0];
        end
    end

    // Square-root stage valid bits: cleared on reset, shifted on advance
    always_ff @(posedge CLK) begin
        if (RST)
            sq_vld <= '0;
        else if (adv)
            sq_vld <= {sq_vld[SQRT_STAGES-2:0], in_valid};
    end

    // Square-root stage payload: loaded on advance, held otherwise
    always_ff @(posedge CLK) begin
        if (adv) begin
            for (int unsigned k = 0; k < SQRT_STAGES; k++) begin
                sq_rem[k]  <= nxt_rem[k];
                sq_root[k] <= nxt_root[k];
                sq_x[k]    <= src_x[k];
                sq_mode[k] <= src_mode[k];
            end
        end
    end

    // Parabolic sine on the root (modes 0/1) or the raw sample (modes 2/3)
    always_comb begin
        y_val = {sq_root[SQRT_STAGES-1], {HALF{1'b0}}};
        if (sq_mode[SQRT_STAGES-1] == MODE_SINE || sq_mode[SQRT_STAGES-1] == MODE_BYPASS)
            t_val = sq_x[SQRT_STAGES-1];
        else
            t_val = y_val;
        t_ext = PW'(t_val);
        comp  = (PW'(1) << WIDTH) - t_ext;
        prod  = t_ext * comp;
        s_ext = prod >> (WIDTH - 2);
        s_val = (|s_ext[PW-1:WIDTH]) ? '1 : s_ext[WIDTH-1:0];
    end

    // Sine stage valid bit
    always_ff @(posedge CLK) begin
        if (RST)
            sn_vld <= 1'b0;
        else if (adv)
            sn_vld <= sq_vld[SQRT_STAGES-1];
    end

    // Sine stage payload: keep every candidate result for the output select
    always_ff @(posedge CLK) begin
        if (adv) begin
            sn_s    <= s_val;
            sn_y    <= y_val;
            sn_x    <= sq_x[SQRT_STAGES-1];
            sn_mode <= sq_mode[SQRT_STAGES-1];
        end
    end

    // Output select by the mode travelling with the sample
    always_comb begin
        case (sn_mode)
            MODE_SQRT:   out_sel = sn_y;
            MODE_BYPASS: out_sel = sn_x;
            default:     out_sel = sn_s;
        endcase
    end

    // Output register: data only updates for a valid sample, held while stalled
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (adv) begin
            out_valid <= sn_vld;
            if (sn_vld)
                out_data <= out_sel;
        end
    end

`ifdef DECOMPOSE_DBG_CNT_EN
    // Debug counters: accepted samples and output stall cycles, wrapping
    always_ff @(posedge CLK) begin
        if (RST) begin
            dbg_acc_cnt   <= '0;
            dbg_stall_cnt <= '0;
        end else begin
            if (in_valid && in_ready)
                dbg_acc_cnt <= dbg_acc_cnt + 16'd1;
            if (out_valid && !out_ready)
                dbg_stall_cnt <= dbg_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_decompose_pipe_hs.sv
// Directed bench for decompose_pipe_hs (WIDTH=16). Expected values are
// hand-computed. The debug counter section builds only with DECOMPOSE_DBG_CNT_EN.
module tb_decompose_pipe_hs;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
`ifdef DECOMPOSE_DBG_CNT_EN
    logic [15:0] dbg_acc_cnt;
    logic [15:0] dbg_stall_cnt;
`endif

    int          errors = 0;
    int          checks = 0;
    logic        last_acc;
    logic [15:0] got[$];

    decompose_pipe_hs #(.WIDTH(16)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef DECOMPOSE_DBG_CNT_EN
        ,
        .dbg_acc_cnt   (dbg_acc_cnt),
        .dbg_stall_cnt (dbg_stall_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Record the handshakes that the coming edge will perform, then advance one cycle
    task automatic tick();
        #1;
        last_acc = in_valid && in_ready;
        if (out_valid === 1'b1 && out_ready === 1'b1)
            got.push_back(out_data);
        @(posedge CLK);
        #1;
    endtask

    // Send one sample into an empty pipe; return cycles to out_valid and the result
    task automatic run_one(input logic [1:0] m, input logic [15:0] x,
                           output int lat, output logic [15:0] d);
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = x;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        d = out_data;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat;
        int          n;
        int          sent;
        logic [15:0] d;
        logic [15:0] held;
        logic        prev_stall;
        logic [1:0]  bm [4];
        logic [15:0] bx [4];
        logic [15:0] be [4];

        bm = '{2'd1, 2'd2, 2'd3, 2'd0};
        bx = '{16'h0900, 16'h4000, 16'h1234, 16'hFFFF};
        be = '{16'h3000, 16'hC000, 16'h1234, 16'h03FC};

        RST = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b1;
        @(posedge CLK);
        #1;
        tick();
        tick();
        RST = 1'b0;
        tick();
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // Compose: sqrt(0x4000)=0x80 -> t=0x8000 -> saturates
        run_one(2'd0, 16'h4000, lat, d);
        check("m0_4000_lat", 32'(lat), 32'd10);
        check("m0_4000_data", 32'(d), 32'hFFFF);
        run_one(2'd0, 16'hFFFF, lat, d);
        check("m0_ffff_lat", 32'(lat), 32'd10);
        check("m0_ffff_data", 32'(d), 32'h03FC);
        run_one(2'd0, 16'h0000, lat, d);
        check("m0_zero_data", 32'(d), 32'h0000);
        run_one(2'd1, 16'h0000, lat, d);
        check("m1_zero_data", 32'(d), 32'h0000);
        run_one(2'd2, 16'h0000, lat, d);
        check("m2_zero_data", 32'(d), 32'h0000);
        run_one(2'd3, 16'h0000, lat, d);
        check("m3_zero_lat", 32'(lat), 32'd10);
        check("m3_zero_data", 32'(d), 32'h0000);

        // Four modes back-to-back, expected on consecutive cycles in order
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_mode  = bm[i];
            in_data  = bx[i];
            tick();
        end
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check("b2b_lat", 32'(n), 32'd6);
        for (int i = 0; i < 4; i++) begin
            check("b2b_valid", 32'(out_valid), 32'd1);
            check("b2b_data", 32'(out_data), 32'(be[i]));
            tick();
        end
        check("b2b_drained", 32'(out_valid), 32'd0);

        // Bypass stream of 20 with a 15-cycle output stall
        got.delete();
        sent = 0;
        held = '0;
        prev_stall = 1'b0;
        for (int c = 0; c < 300 && got.size() < 20; c++) begin
            out_ready = !(c >= 8 && c < 23);
            in_valid  = (sent < 20);
            in_mode   = 2'd3;
            in_data   = 16'(sent);
            if (prev_stall)
                check("stall_hold", 32'(out_data), 32'(held));
            if (c == 15)
                check("stall_in_ready", 32'(in_ready), 32'd0);
            prev_stall = (out_valid === 1'b1) && !out_ready;
            held = out_data;
            tick();
            if (last_acc)
                sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_sent", 32'(sent), 32'd20);
        check("stream_count", 32'(got.size()), 32'd20);
        for (int i = 0; i < 20 && i < got.size(); i++)
            check("stream_order", 32'(got[i]), 32'(i));
        tick();
        check("stream_empty", 32'(out_valid), 32'd0);

        // Reset with 5 samples in flight: none may emerge
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_mode  = 2'd3;
            in_data  = 16'(16'h0100 + i);
            tick();
        end
        in_valid = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("rst_flush_valid", 32'(out_valid), 32'd0);
        check("rst_flush_ready", 32'(in_ready), 32'd1);
        run_one(2'd3, 16'h00AA, lat, d);
        check("rst_next_lat", 32'(lat), 32'd10);
        check("rst_next_data", 32'(d), 32'h00AA);

`ifdef DECOMPOSE_DBG_CNT_EN
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("dbg_rst_acc", 32'(dbg_acc_cnt), 32'd0);
        check("dbg_rst_stall", 32'(dbg_stall_cnt), 32'd0);
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_mode  = 2'd3;
            in_data  = 16'(i);
            tick();
        end
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            tick();
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++)
            tick();
        check("dbg_acc", 32'(dbg_acc_cnt), 32'd7);
        check("dbg_stall", 32'(dbg_stall_cnt), 32'd3);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("dbg_clr_acc", 32'(dbg_acc_cnt), 32'd0);
        check("dbg_clr_stall", 32'(dbg_stall_cnt), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
